// File: rtl/axi_lite_slave_regs_if.sv
// AXI4-Lite bus bundle between a master (testbench or bridge) and the
// axi_lite_slave_regs register file.
interface axi_lite_slave_regs_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WVALID;
    logic                    WREADY;
    logic                    BVALID;
    logic [1:0]              BRESP;
    logic                    BREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic                    RVALID;
    logic [1:0]              RRESP;
    logic                    RREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RDATA, RVALID, RRESP
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BVALID, BRESP, ARREADY, RDATA, RVALID, RRESP
    );
endinterface

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave register file: NUM_REGS words with byte-strobe writes,
// independent write/read FSMs and OKAY/SLVERR responses.
module axi_lite_slave_regs #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 4
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    axi_lite_slave_regs_if.slave s_axi,
    output logic [1:0]           o_dbg_w_state,
    output logic                 o_dbg_r_state
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_WIDTH  = ADDR_WIDTH - 2;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_HAVE_A = 2'd1, W_HAVE_D = 2'd2, W_RESP = 2'd3} w_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

    w_state_t                r_w_state, w_w_state_nxt;
    r_state_t                r_r_state, w_r_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_awaddr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [STRB_WIDTH-1:0]   r_wstrb;
    logic [1:0]              r_bresp;
    logic [DATA_WIDTH-1:0]   r_regs [NUM_REGS];
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [1:0]              r_rresp;

    logic                    w_aw_hs, w_w_hs, w_ar_hs, w_commit;
    logic [ADDR_WIDTH-1:0]   w_cmt_addr;
    logic [DATA_WIDTH-1:0]   w_cmt_data;
    logic [STRB_WIDTH-1:0]   w_cmt_strb;
    logic [IDX_WIDTH-1:0]    w_cmt_idx, w_rd_idx;
    logic                    w_cmt_ok, w_rd_ok;
    logic [DATA_WIDTH-1:0]   w_rd_word;

    // Every channel transfers on a rising edge where VALID && READY. READYs come
    // only from FSM state (and are held low in reset); VALIDs come only from state.
    assign s_axi.AWREADY = ARESETn && (r_w_state == W_IDLE || r_w_state == W_HAVE_D);
    assign s_axi.WREADY  = ARESETn && (r_w_state == W_IDLE || r_w_state == W_HAVE_A);
    assign s_axi.BVALID  = (r_w_state == W_RESP);
    assign s_axi.BRESP   = r_bresp;
    assign s_axi.ARREADY = ARESETn && (r_r_state == R_IDLE);
    assign s_axi.RVALID  = (r_r_state == R_DATA);
    assign s_axi.RDATA   = r_rdata;
    assign s_axi.RRESP   = r_rresp;

    assign o_dbg_w_state = r_w_state;
    assign o_dbg_r_state = r_r_state;

    assign w_aw_hs   = s_axi.AWVALID && s_axi.AWREADY;
    assign w_w_hs    = s_axi.WVALID && s_axi.WREADY;
    assign w_ar_hs   = s_axi.ARVALID && s_axi.ARREADY;
    assign w_cmt_idx = w_cmt_addr[ADDR_WIDTH-1:2];
    assign w_cmt_ok  = int'(w_cmt_idx) < NUM_REGS;
    assign w_rd_idx  = s_axi.ARADDR[ADDR_WIDTH-1:2];
    assign w_rd_ok   = int'(w_rd_idx) < NUM_REGS;

    always_comb begin
        w_w_state_nxt = r_w_state;
        w_commit      = 1'b0;
        w_cmt_addr    = s_axi.AWADDR;
        w_cmt_data    = s_axi.WDATA;
        w_cmt_strb    = s_axi.WSTRB;
        case (r_w_state)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs) begin
                    w_commit      = 1'b1;
                    w_w_state_nxt = W_RESP;
                end else if (w_aw_hs) begin
                    w_w_state_nxt = W_HAVE_A;
                end else if (w_w_hs) begin
                    w_w_state_nxt = W_HAVE_D;
                end
            end
            W_HAVE_A: begin
                w_cmt_addr = r_awaddr;
                if (w_w_hs) begin
                    w_commit      = 1'b1;
                    w_w_state_nxt = W_RESP;
                end
            end
            W_HAVE_D: begin
                w_cmt_data = r_wdata;
                w_cmt_strb = r_wstrb;
                if (w_aw_hs) begin
                    w_commit      = 1'b1;
                    w_w_state_nxt = W_RESP;
                end
            end
            W_RESP: begin
                if (s_axi.BREADY) w_w_state_nxt = W_IDLE;
            end
            default: w_w_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_w_state <= W_IDLE;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bresp   <= 2'b00;
        end else begin
            r_w_state <= w_w_state_nxt;
            if (w_aw_hs) r_awaddr <= s_axi.AWADDR;
            if (w_w_hs) begin
                r_wdata <= s_axi.WDATA;
                r_wstrb <= s_axi.WSTRB;
            end
            if (w_commit) r_bresp <= w_cmt_ok ? 2'b00 : 2'b10;
        end
    end

    // Out-of-range commits match no word, so nothing is written.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_commit) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                for (int b = 0; b < STRB_WIDTH; b++) begin
                    if (w_cmt_idx == IDX_WIDTH'(i) && w_cmt_strb[b])
                        r_regs[i][8*b +: 8] <= w_cmt_data[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_rd_idx == IDX_WIDTH'(i)) w_rd_word = r_regs[i];
        end
    end

    always_comb begin
        w_r_state_nxt = r_r_state;
        case (r_r_state)
            R_IDLE:  if (w_ar_hs) w_r_state_nxt = R_DATA;
            R_DATA:  if (s_axi.RREADY) w_r_state_nxt = R_IDLE;
            default: w_r_state_nxt = R_IDLE;
        endcase
    end

    // RDATA samples the register array before a same-edge write lands.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_r_state <= R_IDLE;
            r_rdata   <= '0;
            r_rresp   <= 2'b00;
        end else begin
            r_r_state <= w_r_state_nxt;
            if (w_ar_hs) begin
                r_rdata <= w_rd_ok ? w_rd_word : '0;
                r_rresp <= w_rd_ok ? 2'b00 : 2'b10;
            end
        end
    end
endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Self-checking bench for axi_lite_slave_regs: directed scenarios plus random
// traffic compared against a word-array model of the register file.
module tb_axi_lite_slave_regs;
    localparam int AW  = 4;
    localparam int DW  = 32;
    localparam int NR  = 3;
    localparam int SW  = DW / 8;
    localparam int TMO = 20;

    logic ACLK    = 1'b0;
    logic ARESETn = 1'b0;
    logic [1:0] dbg_w_state;
    logic       dbg_r_state;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] mdl [NR];
    logic [DW-1:0] exp_q [$];

    always #5 ACLK = ~ACLK;

    axi_lite_slave_regs_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi_lite_slave_regs #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
        .ACLK          (ACLK),
        .ARESETn       (ARESETn),
        .s_axi         (bus.slave),
        .o_dbg_w_state (dbg_w_state),
        .o_dbg_r_state (dbg_r_state)
    );

    // ---------------- reference model ----------------
    function automatic logic [1:0] mdl_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                             input logic [SW-1:0] s);
        int idx;
        logic [DW-1:0] mask;
        idx  = int'(a) / 4;
        mask = '0;
        if (idx >= NR) return 2'b10;
        for (int b = 0; b < SW; b++) if (s[b]) mask[8*b +: 8] = 8'hFF;
        mdl[idx] = (mdl[idx] & ~mask) | (d & mask);
        return 2'b00;
    endfunction

    function automatic logic [1:0] mdl_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
        int idx;
        idx = int'(a) / 4;
        if (idx >= NR) begin
            d = '0;
            return 2'b10;
        end
        d = mdl[idx];
        return 2'b00;
    endfunction

    // ---------------- clock/reset and drivers ----------------
    task automatic cyc(input int n);
        if (n > 0) begin
            repeat (n) @(posedge ACLK);
            #1;
        end
    endtask

    task automatic do_aw(input logic [AW-1:0] a);
        logic rdy;
        int   i;
        rdy = 1'b0;
        i   = 0;
        bus.AWADDR  = a;
        bus.AWVALID = 1'b1;
        while (!rdy && i < TMO) begin
            rdy = bus.AWREADY;
            cyc(1);
            i++;
        end
        if (!rdy) begin
            $display("FAIL aw_timeout: AWREADY got 0, required 1 within %0d cycles", TMO);
            n_err++;
        end
        bus.AWVALID = 1'b0;
    endtask

    task automatic do_w(input logic [DW-1:0] d, input logic [SW-1:0] s);
        logic rdy;
        int   i;
        rdy = 1'b0;
        i   = 0;
        bus.WDATA  = d;
        bus.WSTRB  = s;
        bus.WVALID = 1'b1;
        while (!rdy && i < TMO) begin
            rdy = bus.WREADY;
            cyc(1);
            i++;
        end
        if (!rdy) begin
            $display("FAIL w_timeout: WREADY got 0, required 1 within %0d cycles", TMO);
            n_err++;
        end
        bus.WVALID = 1'b0;
    endtask

    task automatic do_b(output logic [1:0] r);
        logic v;
        int   i;
        v = 1'b0;
        i = 0;
        r = 2'bxx;
        bus.BREADY = 1'b1;
        while (!v && i < TMO) begin
            v = bus.BVALID;
            r = bus.BRESP;
            cyc(1);
            i++;
        end
        if (!v) begin
            $display("FAIL b_timeout: BVALID got 0, required 1 within %0d cycles", TMO);
            n_err++;
        end
        bus.BREADY = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int dly,
                           output logic [DW-1:0] d, output logic [1:0] r);
        logic rdy;
        int   i;
        rdy = 1'b0;
        i   = 0;
        d   = 'x;
        r   = 2'bxx;
        bus.ARADDR  = a;
        bus.ARVALID = 1'b1;
        while (!rdy && i < TMO) begin
            rdy = bus.ARREADY;
            cyc(1);
            i++;
        end
        if (!rdy) begin
            $display("FAIL ar_timeout: ARREADY got 0, required 1 within %0d cycles", TMO);
            n_err++;
        end
        bus.ARVALID = 1'b0;
        cyc(dly);
        bus.RREADY = 1'b1;
        rdy = 1'b0;
        i   = 0;
        while (!rdy && i < TMO) begin
            rdy = bus.RVALID;
            d   = bus.RDATA;
            r   = bus.RRESP;
            cyc(1);
            i++;
        end
        if (!rdy) begin
            $display("FAIL r_timeout: RVALID got 0, required 1 within %0d cycles", TMO);
            n_err++;
        end
        bus.RREADY = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [40:0]   obs;
        logic [DW-1:0] d, ed;
        logic [1:0]    r, er;
        bus.AWADDR = '0; bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WSTRB = '0;
        bus.WVALID = 1'b0; bus.BREADY = 1'b0; bus.ARADDR = '0; bus.ARVALID = 1'b0;
        bus.RREADY = 1'b0;
        ARESETn = 1'b0;
        for (int i = 0; i < NR; i++) mdl[i] = '0;
        for (int c = 0; c < 3; c++) begin
            cyc(1);
            obs = {bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID,
                   bus.BRESP, bus.RRESP, bus.RDATA};
            n_vec++;
            if (obs !== '0) begin
                $display("FAIL reset_outputs: got %h required 0", obs);
                n_err++;
            end
        end
        ARESETn = 1'b1;
        #1;
        n_vec++;
        if ({bus.AWREADY, bus.WREADY, bus.ARREADY} !== 3'b111) begin
            $display("FAIL reset_release_ready: got %b required 111",
                     {bus.AWREADY, bus.WREADY, bus.ARREADY});
            n_err++;
        end
        er = mdl_read(4'h0, ed);
        do_read(4'h0, 0, d, r);
        n_vec++;
        if (d !== ed || r !== er || d !== 32'h0) begin
            $display("FAIL reset_read0: got %h/%b required %h/%b", d, r, ed, er);
            n_err++;
        end
    endtask

    task automatic test_same_edge_write();
        logic [DW-1:0] d, ed;
        logic [1:0]    r, er, eb;
        eb = mdl_write(4'h4, 32'hDEADBEEF, 4'hF);
        fork
            do_aw(4'h4);
            do_w(32'hDEADBEEF, 4'hF);
        join
        n_vec++;
        if (bus.BVALID !== 1'b1 || bus.BRESP !== eb) begin
            $display("FAIL same_edge_bvalid: got %b/%b required 1/%b", bus.BVALID, bus.BRESP, eb);
            n_err++;
        end
        do_b(r);
        n_vec++;
        if (bus.BVALID !== 1'b0 || r !== 2'b00) begin
            $display("FAIL same_edge_bresp: got bvalid %b resp %b required 0/00", bus.BVALID, r);
            n_err++;
        end
        er = mdl_read(4'h4, ed);
        do_read(4'h4, 0, d, r);
        n_vec++;
        if (d !== ed || r !== er || d !== 32'hDEADBEEF) begin
            $display("FAIL same_edge_readback: got %h/%b required %h/%b", d, r, ed, er);
            n_err++;
        end
    endtask

    task automatic test_split_write();
        logic [DW-1:0] d, ed;
        logic [1:0]    r, er, eb;
        eb = mdl_write(4'h8, 32'hFFFFFFFF, 4'hF);
        fork
            do_aw(4'h8);
            do_w(32'hFFFFFFFF, 4'hF);
        join
        do_b(r);
        eb = mdl_write(4'h8, 32'h11223344, 4'h5);
        do_w(32'h11223344, 4'h5);
        n_vec++;
        if ({bus.AWREADY, bus.WREADY, bus.BVALID} !== 3'b100) begin
            $display("FAIL w_first_ready: got %b required 100", {bus.AWREADY, bus.WREADY, bus.BVALID});
            n_err++;
        end
        cyc(2);
        do_aw(4'h8);
        do_b(r);
        n_vec++;
        if (r !== eb) begin
            $display("FAIL w_first_bresp: got %b required %b", r, eb);
            n_err++;
        end
        er = mdl_read(4'h8, ed);
        do_read(4'h8, 0, d, r);
        n_vec++;
        if (d !== ed || r !== er || d !== 32'hFF22FF44) begin
            $display("FAIL w_first_strobe: got %h/%b required %h/%b", d, r, ed, er);
            n_err++;
        end
    endtask

    task automatic test_bready_stall();
        logic [DW-1:0] d, ed, wd;
        logic [1:0]    r, er, eb;
        logic [SW-1:0] ws;
        wd = $urandom;
        eb = mdl_write(4'h0, wd, 4'hF);
        fork
            do_aw(4'h0);
            do_w(wd, 4'hF);
        join
        bus.AWADDR  = 4'h4;
        bus.AWVALID = 1'b1;
        for (int c = 0; c < 5; c++) begin
            n_vec++;
            if ({bus.BVALID, bus.BRESP, bus.AWREADY, bus.WREADY} !== {1'b1, eb, 2'b00}) begin
                $display("FAIL bready_stall: got %b required %b",
                         {bus.BVALID, bus.BRESP, bus.AWREADY, bus.WREADY}, {1'b1, eb, 2'b00});
                n_err++;
            end
            cyc(1);
        end
        do_b(r);
        n_vec++;
        if (r !== eb || bus.AWREADY !== 1'b1) begin
            $display("FAIL bready_release: got resp %b awready %b required %b/1", r, bus.AWREADY, eb);
            n_err++;
        end
        wd = $urandom;
        ws = SW'($urandom_range(1, 15));
        eb = mdl_write(4'h4, wd, ws);
        do_aw(4'h4);
        do_w(wd, ws);
        do_b(r);
        er = mdl_read(4'h4, ed);
        do_read(4'h4, 1, d, r);
        n_vec++;
        if (d !== ed || r !== er) begin
            $display("FAIL stalled_aw_write: got %h/%b required %h/%b", d, r, ed, er);
            n_err++;
        end
    endtask

    task automatic test_out_of_range();
        logic [DW-1:0] d, ed;
        logic [1:0]    r, er, eb;
        eb = mdl_write(4'hC, 32'h5A5A5A5A, 4'hF);
        fork
            do_aw(4'hC);
            do_w(32'h5A5A5A5A, 4'hF);
        join
        do_b(r);
        n_vec++;
        if (r !== eb || r !== 2'b10) begin
            $display("FAIL oor_bresp: got %b required %b", r, eb);
            n_err++;
        end
        for (int i = 0; i < NR; i++) begin
            er = mdl_read(AW'(4 * i), ed);
            do_read(AW'(4 * i), 0, d, r);
            n_vec++;
            if (d !== ed || r !== er) begin
                $display("FAIL oor_regs_kept[%0d]: got %h/%b required %h/%b", i, d, r, ed, er);
                n_err++;
            end
        end
        er = mdl_read(4'hE, ed);
        do_read(4'hE, 0, d, r);
        n_vec++;
        if (d !== ed || r !== er || r !== 2'b10) begin
            $display("FAIL oor_read: got %h/%b required %h/%b", d, r, ed, er);
            n_err++;
        end
    endtask

    task automatic test_same_edge_rw();
        logic [DW-1:0] d, old, wd;
        logic [1:0]    r, rr, eb;
        wd = $urandom;
        old = mdl[2];
        eb = mdl_write(4'h8, wd, 4'hF);
        fork
            do_aw(4'h8);
            do_w(wd, 4'hF);
            do_read(4'h8, 0, d, rr);
        join
        n_vec++;
        if (d !== old || rr !== 2'b00) begin
            $display("FAIL same_edge_rw_old: got %h/%b required %h/00", d, rr, old);
            n_err++;
        end
        do_b(r);
        n_vec++;
        if (r !== eb) begin
            $display("FAIL same_edge_rw_bresp: got %b required %b", r, eb);
            n_err++;
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        logic [DW-1:0] d, wd, ed;
        logic [SW-1:0] s;
        logic [1:0]    r, er, eb;
        int            order, gap;
        for (int it = 0; it < 24; it++) begin
            a     = AW'($urandom_range(0, 15));
            wd    = $urandom;
            s     = SW'($urandom_range(0, 15));
            order = $urandom_range(0, 2);
            gap   = $urandom_range(0, 3);
            eb    = mdl_write(a, wd, s);
            case (order)
                0: fork
                       do_aw(a);
                       do_w(wd, s);
                   join
                1: begin do_aw(a); cyc(gap); do_w(wd, s); end
                default: begin do_w(wd, s); cyc(gap); do_aw(a); end
            endcase
            cyc($urandom_range(0, 3));
            do_b(r);
            n_vec++;
            if (r !== eb) begin
                $display("FAIL rand_bresp[%0d]: addr %h got %b required %b", it, a, r, eb);
                n_err++;
            end
            a  = AW'($urandom_range(0, 15));
            er = mdl_read(a, ed);
            exp_q.push_back(ed);
            do_read(a, $urandom_range(0, 3), d, r);
            ed = exp_q.pop_front();
            n_vec++;
            if (d !== ed || r !== er) begin
                $display("FAIL rand_read[%0d]: addr %h got %h/%b required %h/%b", it, a, d, r, ed, er);
                n_err++;
            end
        end
    endtask

    task automatic test_read_stall_reset();
        logic [DW-1:0] d, ed;
        logic [1:0]    r, er, eb;
        eb = mdl_write(4'h4, 32'hA5A50F0F, 4'hF);
        fork
            do_aw(4'h4);
            do_w(32'hA5A50F0F, 4'hF);
        join
        do_b(r);
        bus.ARADDR  = 4'h4;
        bus.ARVALID = 1'b1;
        n_vec++;
        if (bus.ARREADY !== 1'b1) begin
            $display("FAIL rstall_arready: got %b required 1", bus.ARREADY);
            n_err++;
        end
        cyc(1);
        bus.ARVALID = 1'b0;
        for (int c = 0; c < 4; c++) begin
            n_vec++;
            if ({bus.RVALID, bus.RDATA, bus.RRESP, bus.ARREADY} !== {1'b1, mdl[1], 2'b00, 1'b0}) begin
                $display("FAIL rready_stall: got %b/%h/%b/%b required 1/%h/00/0",
                         bus.RVALID, bus.RDATA, bus.RRESP, bus.ARREADY, mdl[1]);
                n_err++;
            end
            cyc(1);
        end
        #2;
        ARESETn = 1'b0;
        #1;
        for (int i = 0; i < NR; i++) mdl[i] = '0;
        n_vec++;
        if ({bus.RVALID, bus.ARREADY, bus.AWREADY, bus.WREADY, bus.BVALID} !== 5'b0) begin
            $display("FAIL async_reset_drop: got %b required 00000",
                     {bus.RVALID, bus.ARREADY, bus.AWREADY, bus.WREADY, bus.BVALID});
            n_err++;
        end
        @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        #1;
        er = mdl_read(4'h4, ed);
        do_read(4'h4, 0, d, r);
        n_vec++;
        if (d !== ed || r !== er || d !== 32'h0) begin
            $display("FAIL post_reset_read: got %h/%b required %h/%b", d, r, ed, er);
            n_err++;
        end
    endtask

    initial begin
        test_reset();
        test_same_edge_write();
        test_split_write();
        test_bready_stall();
        test_out_of_range();
        test_same_edge_rw();
        test_random();
        test_read_stall_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
